// File: rtl/svpwm_pkg.sv
// Shared definitions for the SVPWM control path: Park-transform FSM state
// encoding, single-precision constants and the default FP phase hold count.
package svpwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL1  = 3'd1,
        ST_MUL2  = 3'd2,
        ST_ADD   = 3'd3,
        ST_LATCH = 3'd4,
        ST_ACK   = 3'd5
    } park_state_e;

    localparam int          OP_LAT_DEF = 12;
    localparam int          WAIT_W     = 6;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;

    // True for NaN or infinity (all-ones exponent).
    function automatic logic fp_is_nan_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF);
    endfunction

endpackage

// File: rtl/park_fsm.sv
// Sequencer for the Park transform: walks IDLE -> MUL1 -> MUL2 -> ADD ->
// LATCH -> ACK, holding each shared-FP phase for OP_LAT+1 cycles.
module park_fsm
    import svpwm_pkg::*;
#(
    parameter int OP_LAT = OP_LAT_DEF
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        en,
    output park_state_e state_q,
    output park_state_e state_d,
    output logic        phase_done
);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;

    assign phase_done = (wait_cnt_q == WAIT_W'(OP_LAT));

    // Next state and phase wait counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en)         state_d = ST_MUL1;
            ST_MUL1:  if (phase_done) state_d = ST_MUL2;
            ST_MUL2:  if (phase_done) state_d = ST_ADD;
            ST_ADD:   if (phase_done) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // State and counter registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/park.sv
// Park transform (alpha/beta -> d/q) built on two shared FP multipliers and
// two shared FP adders. Optional macro PARK_NAN_FILTER_EN: results with an
// all-ones exponent are dropped at latch time and flag sticky nan_err.
module park
    import svpwm_pkg::*;
#(
    parameter int OP_LAT = OP_LAT_DEF
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] I_alpha,
    input  logic [31:0] I_beta,
    input  logic [31:0] sin_theta,
    input  logic [31:0] cos_theta,
    input  logic [31:0] re_mult1,
    input  logic [31:0] re_mult2,
    input  logic [31:0] re_add1,
    input  logic [31:0] re_add2,
    output logic [31:0] mult1a,
    output logic [31:0] mult1b,
    output logic [31:0] mult2a,
    output logic [31:0] mult2b,
    output logic [31:0] add1a,
    output logic [31:0] add1b,
    output logic [31:0] add2a,
    output logic [31:0] add2b,
    output logic        isadd1,
    output logic        isadd2,
    output logic [31:0] I_d,
    output logic [31:0] I_q,
    output logic        ack
`ifdef PARK_NAN_FILTER_EN
    ,
    output logic        nan_err
`endif
);

    park_state_e state_q;
    park_state_e state_d;
    logic        phase_done;

    park_fsm #(.OP_LAT(OP_LAT)) u_fsm (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .en         (en),
        .state_q    (state_q),
        .state_d    (state_d),
        .phase_done (phase_done)
    );

    logic [31:0] mult1a_q, mult1b_q, mult2a_q, mult2b_q;
    logic [31:0] mult1a_d, mult1b_d, mult2a_d, mult2b_d;
    logic [31:0] add1a_q, add1b_q, add2a_q, add2b_q;
    logic [31:0] add1a_d, add1b_d, add2a_d, add2b_d;
    logic        isadd1_q, isadd2_q, isadd1_d, isadd2_d;
    logic [31:0] p1_q, p2_q, p3_q, p4_q;
    logic [31:0] p1_d, p2_d, p3_d, p4_d;
    logic [31:0] i_d_q, i_q_q, i_d_d, i_q_d;
    logic        nan_err_q, nan_err_d;

    // Operand loading on state entry, product capture, result latching.
    always_comb begin
        mult1a_d  = mult1a_q;
        mult1b_d  = mult1b_q;
        mult2a_d  = mult2a_q;
        mult2b_d  = mult2b_q;
        add1a_d   = add1a_q;
        add1b_d   = add1b_q;
        add2a_d   = add2a_q;
        add2b_d   = add2b_q;
        isadd1_d  = isadd1_q;
        isadd2_d  = isadd2_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        p3_d      = p3_q;
        p4_d      = p4_q;
        i_d_d     = i_d_q;
        i_q_d     = i_q_q;
        nan_err_d = nan_err_q;

        // Products are taken on the final cycle of their phase.
        if ((state_q == ST_MUL1) && phase_done) begin
            p1_d = re_mult1;
            p2_d = re_mult2;
        end
        if ((state_q == ST_MUL2) && phase_done) begin
            p3_d = re_mult1;
            p4_d = re_mult2;
        end

        // ADD entry coincides with P3/P4 capture, so use the _d values.
        if (state_d != state_q) begin
            case (state_d)
                ST_MUL1: begin
                    mult1a_d = I_alpha;
                    mult1b_d = cos_theta;
                    mult2a_d = I_beta;
                    mult2b_d = sin_theta;
                end
                ST_MUL2: begin
                    mult1a_d = I_alpha;
                    mult1b_d = sin_theta;
                    mult2a_d = I_beta;
                    mult2b_d = cos_theta;
                end
                ST_ADD: begin
                    add1a_d  = p1_d;
                    add1b_d  = p2_d;
                    isadd1_d = 1'b1;
                    add2a_d  = p4_d;
                    add2b_d  = p3_d;
                    isadd2_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (state_q == ST_LATCH) begin
`ifdef PARK_NAN_FILTER_EN
            if (fp_is_nan_inf(re_add1)) nan_err_d = 1'b1;
            else                        i_d_d     = re_add1;
            if (fp_is_nan_inf(re_add2)) nan_err_d = 1'b1;
            else                        i_q_d     = re_add2;
`else
            i_d_d = re_add1;
            i_q_d = re_add2;
`endif
        end
    end

    // Datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mult1a_q  <= FP_ZERO;
            mult1b_q  <= FP_ZERO;
            mult2a_q  <= FP_ZERO;
            mult2b_q  <= FP_ZERO;
            add1a_q   <= FP_ZERO;
            add1b_q   <= FP_ZERO;
            add2a_q   <= FP_ZERO;
            add2b_q   <= FP_ZERO;
            isadd1_q  <= 1'b0;
            isadd2_q  <= 1'b0;
            p1_q      <= FP_ZERO;
            p2_q      <= FP_ZERO;
            p3_q      <= FP_ZERO;
            p4_q      <= FP_ZERO;
            i_d_q     <= FP_ZERO;
            i_q_q     <= FP_ZERO;
            nan_err_q <= 1'b0;
        end else begin
            mult1a_q  <= mult1a_d;
            mult1b_q  <= mult1b_d;
            mult2a_q  <= mult2a_d;
            mult2b_q  <= mult2b_d;
            add1a_q   <= add1a_d;
            add1b_q   <= add1b_d;
            add2a_q   <= add2a_d;
            add2b_q   <= add2b_d;
            isadd1_q  <= isadd1_d;
            isadd2_q  <= isadd2_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            p3_q      <= p3_d;
            p4_q      <= p4_d;
            i_d_q     <= i_d_d;
            i_q_q     <= i_q_d;
            nan_err_q <= nan_err_d;
        end
    end

    assign mult1a = mult1a_q;
    assign mult1b = mult1b_q;
    assign mult2a = mult2a_q;
    assign mult2b = mult2b_q;
    assign add1a  = add1a_q;
    assign add1b  = add1b_q;
    assign add2a  = add2a_q;
    assign add2b  = add2b_q;
    assign isadd1 = isadd1_q;
    assign isadd2 = isadd2_q;
    assign I_d    = i_d_q;
    assign I_q    = i_q_q;
    assign ack    = (state_q == ST_ACK);

`ifdef PARK_NAN_FILTER_EN
    assign nan_err = nan_err_q;
`else
    logic unused_nan;
    assign unused_nan = nan_err_q;
`endif

endmodule

// File: tb/tb_park.sv
// Bench for park: behavioural FP units, directed runs, scoreboard of
// expected {I_d, I_q} checked on every ack pulse.
module tb_park;

    localparam int OP_LAT = 12;
    localparam int LAT    = 3 * (OP_LAT + 1) + 2;
    localparam int PERIOD = 3 * (OP_LAT + 1) + 3;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic [31:0] I_alpha = '0, I_beta = '0, sin_theta = '0, cos_theta = '0;
    logic [31:0] re_mult1, re_mult2, re_add1, re_add2;
    logic [31:0] mult1a, mult1b, mult2a, mult2b, add1a, add1b, add2a, add2b;
    logic        isadd1, isadd2, ack;
    logic [31:0] I_d, I_q;
`ifdef PARK_NAN_FILTER_EN
    logic        nan_err;
`endif

    park #(.OP_LAT(OP_LAT)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en),
        .I_alpha(I_alpha), .I_beta(I_beta), .sin_theta(sin_theta), .cos_theta(cos_theta),
        .re_mult1(re_mult1), .re_mult2(re_mult2), .re_add1(re_add1), .re_add2(re_add2),
        .mult1a(mult1a), .mult1b(mult1b), .mult2a(mult2a), .mult2b(mult2b),
        .add1a(add1a), .add1b(add1b), .add2a(add2a), .add2b(add2b),
        .isadd1(isadd1), .isadd2(isadd2), .I_d(I_d), .I_q(I_q), .ack(ack)
`ifdef PARK_NAN_FILTER_EN
        , .nan_err(nan_err)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural single-precision arithmetic (exact for the values used).
    function automatic real fp2real(input logic [31:0] v);
        real r;
        int  e;
        if (v[30:23] == 8'h00) return 0.0;
        r = 1.0 + real'(v[22:0]) / 8388608.0;
        e = int'(v[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return v[31] ? -r : r;
    endfunction

    function automatic logic [31:0] real2fp(input real r);
        logic [63:0] b;
        int          e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], 8'(e), b[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
        return real2fp(fp2real(a) * fp2real(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic add);
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
        return add ? real2fp(fp2real(a) + fp2real(b)) : real2fp(fp2real(a) - fp2real(b));
    endfunction

    always_comb begin
        re_mult1 = fmul(mult1a, mult1b);
        re_mult2 = fmul(mult2a, mult2b);
        re_add1  = fadd(add1a, add1b, isadd1);
        re_add2  = fadd(add2a, add2b, isadd2);
    end

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          ack_cnt = 0;
    int          ack_cyc_q[$];
    logic [63:0] exp_q[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every ack pops one expected result.
    always @(negedge sys_clk) begin
        logic [63:0] e;
        if (rst_n === 1'b1 && ack === 1'b1) begin
            ack_cnt++;
            ack_cyc_q.push_back(cyc);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_ack: observed ack at cycle %0d expected none", cyc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check32("I_d", I_d, e[63:32]);
                check32("I_q", I_q, e[31:0]);
            end
        end
    end

    task automatic set_inputs(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] s);
        I_alpha = a; I_beta = b; cos_theta = c; sin_theta = s;
    endtask

    // One-cycle en pulse; t0 is the cycle count on the drive edge.
    task automatic start_run(output int t0);
        @(negedge sys_clk);
        en = 1'b1;
        t0 = cyc;
        @(negedge sys_clk);
        en = 1'b0;
    endtask

    task automatic wait_ack(input int prev, input string tag);
        int n;
        n = 0;
        while (ack_cnt <= prev && n < 200) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        checks++;
        assert (ack_cnt > prev) else begin
            errors++;
            $error("FAIL %s_timeout: observed %0d acks expected more than %0d", tag, ack_cnt, prev);
        end
    endtask

    task automatic check_latency(input string tag, input int t0);
        check32(tag, 32'(ack_cyc_q[ack_cyc_q.size()-1] - t0), 32'(LAT));
    endtask

    initial begin
        int t0;
        int base;

        // Reset state.
        repeat (3) @(negedge sys_clk);
        check32("rst_ack", 32'(ack), 32'd0);
        check32("rst_I_d", I_d, 32'h0);
        check32("rst_I_q", I_q, 32'h0);
        check32("rst_mult1a", mult1a, 32'h0);
        check32("rst_isadd1", 32'(isadd1), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Identity angle.
        set_inputs(32'h3F800000, 32'h0, 32'h3F800000, 32'h0);
        exp_q.push_back({32'h3F800000, 32'h00000000});
        base = ack_cnt;
        start_run(t0);
        wait_ack(base, "run_a");
        check_latency("lat_a", t0);

        // Quarter turn, with en pulses while busy.
        set_inputs(32'h3F800000, 32'h40000000, 32'h0, 32'h3F800000);
        exp_q.push_back({32'h40000000, 32'hBF800000});
        base = ack_cnt;
        start_run(t0);
        for (int k = 2; k <= 40; k++) begin
            en = (k == 5 || k == 20 || k == 38 || k == 40);
            @(negedge sys_clk);
        end
        en = 1'b0;
        wait_ack(base, "run_b");
        check_latency("lat_b", t0);
        repeat (45) @(negedge sys_clk);
        check32("busy_en_ignored", 32'(ack_cnt), 32'(base + 1));

        // Fractional operands.
        set_inputs(32'h40000000, 32'h40400000, 32'h3F000000, 32'h3E800000);
        exp_q.push_back({32'h3FE00000, 32'h3F800000});
        base = ack_cnt;
        start_run(t0);
        wait_ack(base, "run_c");
        check_latency("lat_c", t0);

        // Negative alpha, cancelling I_d.
        set_inputs(32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        exp_q.push_back({32'h00000000, 32'h40000000});
        base = ack_cnt;
        start_run(t0);
        wait_ack(base, "run_d");

        // en held high for three back-to-back runs.
        set_inputs(32'h3F800000, 32'h0, 32'h3F800000, 32'h0);
        for (int k = 0; k < 3; k++) exp_q.push_back({32'h3F800000, 32'h00000000});
        base = ack_cnt;
        @(negedge sys_clk);
        en = 1'b1;
        t0 = cyc;
        wait_ack(base, "held_1");
        wait_ack(base + 1, "held_2");
        repeat (5) @(negedge sys_clk);
        en = 1'b0;
        wait_ack(base + 2, "held_3");
        check_latency("lat_held", t0 + 2 * PERIOD);
        check32("held_spacing_1", 32'(ack_cyc_q[base + 1] - ack_cyc_q[base]), 32'(PERIOD));
        check32("held_spacing_2", 32'(ack_cyc_q[base + 2] - ack_cyc_q[base + 1]), 32'(PERIOD));
        repeat (60) @(negedge sys_clk);
        check32("held_ack_count", 32'(ack_cnt), 32'(base + 3));

        // Reset in MUL2 at wait count 5: run aborted, no ack.
        set_inputs(32'h40000000, 32'h40400000, 32'h3F000000, 32'h3E800000);
        base = ack_cnt;
        start_run(t0);
        repeat (18) @(negedge sys_clk);
        check32("mul2_mult1a", mult1a, 32'h40000000);
        check32("mul2_mult1b", mult1b, 32'h3E800000);
        check32("mul2_mult2b", mult2b, 32'h3F000000);
        rst_n = 1'b0;
        #1;
        check32("abort_I_d", I_d, 32'h0);
        check32("abort_I_q", I_q, 32'h0);
        check32("abort_ack", 32'(ack), 32'd0);
        check32("abort_mult1a", mult1a, 32'h0);
        check32("abort_add1a", add1a, 32'h0);
        check32("abort_isadd1", 32'(isadd1), 32'd0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (50) @(negedge sys_clk);
        check32("abort_no_ack", 32'(ack_cnt), 32'(base));

        // Fresh run after reset.
        set_inputs(32'h3F800000, 32'h40000000, 32'h0, 32'h3F800000);
        exp_q.push_back({32'h40000000, 32'hBF800000});
        base = ack_cnt;
        start_run(t0);
        wait_ack(base, "run_post_rst");
        check_latency("lat_post_rst", t0);

`ifdef PARK_NAN_FILTER_EN
        // NaN input: outputs hold, sticky error, ack still pulses.
        check32("nan_err_clear", 32'(nan_err), 32'd0);
        set_inputs(32'h7FC00000, 32'h40000000, 32'h0, 32'h3F800000);
        exp_q.push_back({32'h40000000, 32'hBF800000});
        base = ack_cnt;
        start_run(t0);
        wait_ack(base, "run_nan");
        check32("nan_err_set", 32'(nan_err), 32'd1);
        repeat (3) @(negedge sys_clk);
        check32("nan_err_sticky", 32'(nan_err), 32'd1);
`endif

        repeat (3) @(negedge sys_clk);
        check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/park.md
PARK -- requirements
Module: park

Interface
REQ-001 SHALL have parameter OP_LAT, default 12, meaning the wait count (cycles minus one) each shared FP multiply/add phase is held.
REQ-002 SHALL have port sys_clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port I_alpha  input  32  alpha current, IEEE-754 single.
REQ-006 SHALL have port I_beta  input  32  beta current, IEEE-754 single.
REQ-007 SHALL have port sin_theta  input  32  sin of rotor angle, IEEE-754 single.
REQ-008 SHALL have port cos_theta  input  32  cos of rotor angle, IEEE-754 single.
REQ-009 SHALL have ports re_mult1, re_mult2, re_add1, re_add2  input  32 each  results from shared FP units.
REQ-010 SHALL have ports mult1a, mult1b, mult2a, mult2b, add1a, add1b, add2a, add2b  output  32 each  registered operands to shared FP units.
REQ-011 SHALL have ports isadd1, isadd2  output  1 each  adder mode: 1 = a+b, 0 = a-b.
REQ-012 SHALL have port I_d  output  32  direct-axis current, registered.
REQ-013 SHALL have port I_q  output  32  quadrature-axis current, registered.
REQ-014 SHALL have port ack  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL compute I_d = I_alpha*cos + I_beta*sin and I_q = I_beta*cos - I_alpha*sin.
REQ-016 SHALL implement states IDLE, MUL1, MUL2, ADD, LATCH, ACK; ack = (state==ACK).
REQ-017 SHALL move IDLE->MUL1 when en=1; MUL1->MUL2, MUL2->ADD, ADD->LATCH when wait_cnt==OP_LAT; LATCH->ACK->IDLE unconditionally; undefined states -> IDLE.
REQ-018 SHALL clear wait_cnt (6 bits) on every state change and in IDLE, else increment.
REQ-019 SHALL load operands only on the edge entering a state: MUL1 {alpha,cos},{beta,sin}; MUL2 {alpha,sin},{beta,cos}; ADD add1={P1,P2} isadd1=1, add2={P4,P3} isadd2=0; operands hold otherwise.
REQ-020 SHALL capture P1/P2 from re_mult1/2 on the last MUL1 cycle and P3/P4 on the last MUL2 cycle.
REQ-021 SHALL register I_d<=re_add1, I_q<=re_add2 during LATCH.
REQ-022 SHALL assert ack exactly 3*(OP_LAT+1)+2 cycles after the edge sampling en=1 (41 at default); I_d/I_q valid when ack=1 and held until next LATCH.
REQ-023 SHALL ignore en outside IDLE; en held high yields back-to-back runs, period 3*(OP_LAT+1)+3 cycles (42 at default).
REQ-024 SHALL sample I_alpha, I_beta, sin_theta, cos_theta only at MUL1/MUL2 entry; upstream holds them stable from en until ack.

Reset
REQ-025 SHALL, on rst_n=0 at any time, force state=IDLE, wait_cnt=0, all operands, products, I_d, I_q = 32'h0, isadd1=isadd2=0, ack=0.
REQ-026 SHALL abort any run on reset mid-operation; no ack is issued for the aborted run.

Configuration
REQ-027 SHALL support macro PARK_NAN_FILTER_EN: when defined, a result with exponent 8'hFF (NaN/Inf) in LATCH leaves that output at its previous value and sets output nan_err (1 bit, sticky, cleared by reset); ack still pulses.
REQ-028 SHALL, without PARK_NAN_FILTER_EN, have no nan_err port and latch results unconditionally.

Structure
REQ-029 SHALL place state encoding, FP constants (zero 32'h0, one 32'h3F800000) and OP_LAT default in shared package svpwm_pkg.
REQ-030 SHALL factor state register, wait_cnt and next-state logic into sub-module park_fsm; datapath registers remain in park.

Verification (bench provides behavioural FP mult/add, latency <= OP_LAT)
REQ-031 SHALL verify alpha=3F800000, beta=0, cos=3F800000, sin=0 -> I_d=3F800000, I_q=00000000, ack 41 cycles after en.
REQ-032 SHALL verify alpha=3F800000, beta=40000000, cos=0, sin=3F800000 -> I_d=40000000, I_q=BF800000.
REQ-033 SHALL verify en held high for 3 runs -> exactly 3 ack pulses spaced 42 cycles, en pulses during busy ignored.
REQ-034 SHALL verify rst_n low at MUL2 wait_cnt=5 -> all outputs 0 next cycle, no ack, fresh run correct after release.
REQ-035 SHALL verify with PARK_NAN_FILTER_EN, alpha=7FC00000 after a valid run -> I_d/I_q hold prior values, nan_err=1, ack pulses.
